alu_sequencer: RTL and testbench

Control sequencer that drives the ALU's operand, op and branch-address ports and consumes its result and flags. It fetches 9-bit instructions from a synchronous 64-entry instruction memory, reads a 4×8-bit register file, issues one ALU operation per instruction, writes back the result, and redirects the PC when the ALU raises its branch flag. It is the driving end of the ALU interface and sits between instruction memory and the ALU in the processor top level.

---
 rtl/alu_pkg.sv | 39 +++
 rtl/regfile4x8.sv | 36 +++
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared constants, opcode encodings and FSM state type for the ALU sequencer.
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int ADDR_W  = 6;
    localparam int INSTR_W = 9;
    localparam int OP_W    = 3;
    localparam int NUM_REGS = 4;

    localparam logic [OP_W-1:0] OP_NOP = 3'b000;
    localparam logic [OP_W-1:0] OP_ADD = 3'b001;
    localparam logic [OP_W-1:0] OP_SUB = 3'b010;
    localparam logic [OP_W-1:0] OP_AND = 3'b011;
    localparam logic [OP_W-1:0] OP_NOT = 3'b100;
    localparam logic [OP_W-1:0] OP_OR  = 3'b101;
    localparam logic [OP_W-1:0] OP_EQ  = 3'b110;
    localparam logic [OP_W-1:0] OP_BR  = 3'b111;

    localparam logic [ADDR_W-1:0] HALT_FIELD = 6'h3F;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    // Only the ALU data ops produce a register result; NOP and BR do not.
    function automatic logic op_writes_rd(input logic [OP_W-1:0] op);
        return (op != OP_NOP) && (op != OP_BR);
    endfunction

    function automatic logic op_sets_carry(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/regfile4x8.sv
// Four 8-bit registers: two operand read ports, a debug read port and one
// synchronous write port, all cleared by the synchronous reset.
module regfile4x8
    import alu_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_we,
    input  logic [1:0]        i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [1:0]        i_raddr_a,
    input  logic [1:0]        i_raddr_b,
    input  logic [1:0]        i_dbg_sel,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b,
    output logic [DATA_W-1:0] o_dbg_data
);

    logic [DATA_W-1:0] r_regs [0:NUM_REGS-1];

    // Register storage: clear on reset, otherwise single-port write
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_W{1'b0}};
            end
        end else if (i_we) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata_a  = r_regs[i_raddr_a];
    assign o_rdata_b  = r_regs[i_raddr_b];
    assign o_dbg_data = r_regs[i_dbg_sel];

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/execute/writeback sequencer driving an external registered ALU;
// owns the PC, instruction register and the register file.
module alu_sequencer
    import alu_pkg::*;
(
    input  logic               CLK,
    input  logic               RST,
    input  logic               run,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [DATA_W-1:0]  alu_a,
    output logic [DATA_W-1:0]  alu_b,
    output logic [ADDR_W-1:0]  alu_addr,
    output logic [OP_W-1:0]    alu_op,
    input  logic [DATA_W-1:0]  alu_out,
    input  logic               alu_co,
    input  logic               alu_eq,
    input  logic               alu_branch,
    output logic [ADDR_W-1:0]  pc,
    output logic               carry,
    output logic               halted,
    input  logic [1:0]         dbg_sel,
    output logic [DATA_W-1:0]  dbg_data
);

    state_t               r_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [ADDR_W-1:0]    r_imem_addr;
    logic [INSTR_W-1:0]   r_ir;
    logic [DATA_W-1:0]    r_alu_a;
    logic [DATA_W-1:0]    r_alu_b;
    logic [ADDR_W-1:0]    r_alu_addr;
    logic [OP_W-1:0]      r_alu_op;
    logic                 r_carry;
    logic                 r_halted;

    logic [OP_W-1:0]      w_dec_op;
    logic [ADDR_W-1:0]    w_dec_field;
    logic                 w_dec_halt;
    logic [DATA_W-1:0]    w_rdata_a;
    logic [DATA_W-1:0]    w_rdata_b;
    logic                 w_we;
    logic [ADDR_W-1:0]    w_pc_next;
    logic                 w_unused;

    // Operand reads are addressed straight from the memory word during DECODE.
    assign w_dec_op    = imem_data[8:6];
    assign w_dec_field = imem_data[5:0];
    assign w_dec_halt  = (w_dec_op == OP_NOP) && (w_dec_field == HALT_FIELD);

    regfile4x8 u_regfile (
        .i_clk      (CLK),
        .i_rst      (RST),
        .i_we       (w_we),
        .i_waddr    (r_ir[5:4]),
        .i_wdata    (alu_out),
        .i_raddr_a  (imem_data[3:2]),
        .i_raddr_b  (imem_data[1:0]),
        .i_dbg_sel  (dbg_sel),
        .o_rdata_a  (w_rdata_a),
        .o_rdata_b  (w_rdata_b),
        .o_dbg_data (dbg_data)
    );

    // Writeback enable and next PC (branch target is the held alu_addr)
    always_comb begin
        w_we = 1'b0;
        if (r_state == ST_WB) begin
            w_we = op_writes_rd(r_ir[8:6]);
        end else begin
            w_we = 1'b0;
        end
        if (alu_branch) begin
            w_pc_next = r_alu_addr;
        end else begin
            w_pc_next = r_pc + 6'd1;
        end
    end

    // Sequencer FSM with registered memory and ALU-side outputs
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_IDLE;
            r_pc        <= {ADDR_W{1'b0}};
            r_imem_addr <= {ADDR_W{1'b0}};
            r_ir        <= {INSTR_W{1'b0}};
            r_alu_a     <= {DATA_W{1'b0}};
            r_alu_b     <= {DATA_W{1'b0}};
            r_alu_addr  <= {ADDR_W{1'b0}};
            r_alu_op    <= OP_NOP;
            r_carry     <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (run) begin
                        r_imem_addr <= r_pc;
                        r_state     <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    r_state <= ST_DECODE;
                end
                ST_DECODE: begin
                    r_ir <= imem_data;
                    if (w_dec_halt) begin
                        r_halted <= 1'b1;
                        r_state  <= ST_HALT;
                    end else begin
                        r_alu_op   <= w_dec_op;
                        r_alu_a    <= w_rdata_a;
                        r_alu_b    <= w_rdata_b;
                        r_alu_addr <= w_dec_field;
                        r_state    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_state <= ST_WB;
                end
                ST_WB: begin
                    if (op_sets_carry(r_ir[8:6])) begin
                        r_carry <= alu_co;
                    end
                    r_pc       <= w_pc_next;
                    r_alu_op   <= OP_NOP;
                    r_alu_a    <= {DATA_W{1'b0}};
                    r_alu_b    <= {DATA_W{1'b0}};
                    r_alu_addr <= {ADDR_W{1'b0}};
                    if (run) begin
                        r_imem_addr <= w_pc_next;
                        r_state     <= ST_FETCH;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign w_unused  = ^{alu_eq, r_ir[3:0]};

    assign imem_addr = r_imem_addr;
    assign alu_a     = r_alu_a;
    assign alu_b     = r_alu_b;
    assign alu_addr  = r_alu_addr;
    assign alu_op    = r_alu_op;
    assign pc        = r_pc;
    assign carry     = r_carry;
    assign halted    = r_halted;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a synchronous instruction memory and a
// registered reference ALU; every expected value is hand-computed.
module tb_alu_sequencer;

    logic       CLK = 1'b0;
    logic       RST;
    logic       run;
    logic [5:0] imem_addr;
    logic [8:0] imem_data;
    logic [7:0] alu_a, alu_b, alu_out;
    logic [5:0] alu_addr;
    logic [2:0] alu_op;
    logic       alu_co, alu_eq, alu_branch;
    logic [5:0] pc;
    logic       carry, halted;
    logic [1:0] dbg_sel;
    logic [7:0] dbg_data;

    logic [8:0] imem [0:63];
    logic       eq_flag;
    int         checks = 0;
    int         failures = 0;
    logic [2:0] ex_op;
    logic [7:0] ex_a, ex_b;
    logic [5:0] ex_addr;

    localparam logic [2:0] NOP = 3'b000, ADD = 3'b001, SUB = 3'b010, AND = 3'b011;
    localparam logic [2:0] NOT = 3'b100, OR  = 3'b101, EQ  = 3'b110, BR  = 3'b111;

    always #5 CLK = ~CLK;

    alu_sequencer dut (
        .CLK        (CLK),
        .RST        (RST),
        .run        (run),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_addr   (alu_addr),
        .alu_op     (alu_op),
        .alu_out    (alu_out),
        .alu_co     (alu_co),
        .alu_eq     (alu_eq),
        .alu_branch (alu_branch),
        .pc         (pc),
        .carry      (carry),
        .halted     (halted),
        .dbg_sel    (dbg_sel),
        .dbg_data   (dbg_data)
    );

    // Synchronous instruction memory: data one cycle after the address
    always @(posedge CLK) imem_data <= imem[imem_addr];

    // Reference ALU: registered result, EQ sets a sticky flag that BR consumes
    always @(posedge CLK) begin
        if (RST) begin
            alu_out <= 8'h00; alu_co <= 1'b0; alu_branch <= 1'b0; eq_flag <= 1'b0;
        end else begin
            alu_branch <= 1'b0;
            case (alu_op)
                ADD: {alu_co, alu_out} <= {1'b0, alu_a} + {1'b0, alu_b};
                SUB: {alu_co, alu_out} <= {1'b0, alu_a} - {1'b0, alu_b};
                AND: alu_out <= alu_a & alu_b;
                NOT: alu_out <= ~alu_a;
                OR:  alu_out <= alu_a | alu_b;
                EQ:  begin alu_out <= {7'd0, alu_a == alu_b}; eq_flag <= (alu_a == alu_b); end
                BR:  alu_branch <= eq_flag;
                default: ;
            endcase
        end
    end
    assign alu_eq = eq_flag;

    initial begin
        #50000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [1:0] rd,
                                       input logic [1:0] ra, input logic [1:0] rb);
        return {op, rd, ra, rb};
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_reg(input string tag, input logic [1:0] idx, input logic [7:0] exp);
        dbg_sel = idx;
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    // From FETCH: capture EXEC outputs, pass WB, end one cycle after WB.
    task automatic next_instr(input logic drop);
        repeat (2) @(posedge CLK);
        #1;
        ex_op = alu_op; ex_a = alu_a; ex_b = alu_b; ex_addr = alu_addr;
        if (drop) run = 1'b0;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
    endtask

    initial begin
        RST = 1'b1; run = 1'b0; dbg_sel = 2'd0;
        for (int i = 0; i < 64; i++) imem[i] = 9'd0;
        imem[0]  = enc(NOT, 2'd1, 2'd0, 2'd0);   // r1 = FF
        imem[1]  = enc(EQ,  2'd2, 2'd0, 2'd0);   // r2 = 01
        imem[2]  = enc(ADD, 2'd0, 2'd1, 2'd2);   // r0 = 00, carry 1
        imem[3]  = enc(ADD, 2'd3, 2'd2, 2'd2);   // r3 = 02
        imem[4]  = enc(ADD, 2'd3, 2'd3, 2'd2);   // r3 = 03
        imem[5]  = enc(ADD, 2'd0, 2'd3, 2'd3);   // r0 = 06
        imem[6]  = enc(ADD, 2'd0, 2'd0, 2'd0);   // r0 = 0C
        imem[7]  = enc(ADD, 2'd0, 2'd0, 2'd0);   // r0 = 18
        imem[8]  = enc(SUB, 2'd1, 2'd0, 2'd3);   // r1 = 15
        imem[9]  = enc(OR,  2'd2, 2'd3, 2'd3);   // r2 = 03
        imem[10] = enc(SUB, 2'd3, 2'd1, 2'd2);
        imem[11] = enc(AND, 2'd0, 2'd1, 2'd2);
        imem[12] = enc(NOT, 2'd0, 2'd1, 2'd2);
        imem[13] = enc(OR,  2'd0, 2'd1, 2'd2);
        imem[14] = enc(EQ,  2'd0, 2'd1, 2'd2);
        imem[15] = {BR, 6'h24};
        imem[16] = enc(EQ,  2'd0, 2'd2, 2'd2);
        imem[17] = {BR, 6'h24};
        imem[36] = {BR, 6'h3F};
        imem[63] = 9'd0;

        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_alu_ab", 32'({alu_a, alu_b}), 32'd0);
        check("rst_alu_addr", 32'(alu_addr), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        for (int i = 0; i < 4; i++) check_reg("rst_reg", 2'(i), 8'h00);

        repeat (3) @(posedge CLK);
        #1;
        check("idle_pc", 32'(pc), 32'd0);
        check("idle_alu_op", 32'(alu_op), 32'd0);

        run = 1'b1;
        @(posedge CLK); #1;
        next_instr(1'b0);
        check("first_op_cycle3", 32'(ex_op), 32'(NOT));
        check_reg("not_r1", 2'd1, 8'hFF);
        next_instr(1'b0);
        check_reg("eq_r2", 2'd2, 8'h01);
        next_instr(1'b0);
        check("add_a", 32'(ex_a), 32'h00FF);
        check("add_b", 32'(ex_b), 32'h0001);
        check_reg("add_r0", 2'd0, 8'h00);
        check("add_carry", 32'(carry), 32'd1);
        check("add_pc", 32'(pc), 32'd3);

        for (int k = 3; k <= 9; k++) next_instr(1'b0);
        check("setup_pc", 32'(pc), 32'd10);
        check_reg("setup_r1", 2'd1, 8'h15);
        check_reg("setup_r2", 2'd2, 8'h03);

        next_instr(1'b0);
        check("sub_exec", 32'({ex_op, ex_a, ex_b}), 32'({SUB, 8'h15, 8'h03}));
        check_reg("sub_r3", 2'd3, 8'h12);
        check("sub_carry", 32'(carry), 32'd0);
        next_instr(1'b0);
        check_reg("and_r0", 2'd0, 8'h01);
        next_instr(1'b0);
        check("not_b_driven", 32'(ex_b), 32'h0003);
        check_reg("not_r0", 2'd0, 8'hEA);
        next_instr(1'b0);
        check_reg("or_r0", 2'd0, 8'h17);
        next_instr(1'b0);
        check_reg("eq_r0", 2'd0, 8'h00);
        next_instr(1'b0);
        check("br_not_taken_pc", 32'(pc), 32'd16);
        next_instr(1'b0);
        check_reg("eq_equal_r0", 2'd0, 8'h01);
        next_instr(1'b0);
        check("br_exec_addr", 32'(ex_addr), 32'h24);
        check("br_taken_pc", 32'(pc), 32'd36);
        check("br_fetch_addr", 32'(imem_addr), 32'd36);
        next_instr(1'b0);
        check("br_to_63_pc", 32'(pc), 32'd63);

        next_instr(1'b1);
        check("wrap_pc", 32'(pc), 32'd0);
        check_reg("nop_no_write", 2'd0, 8'h01);
        repeat (3) @(posedge CLK);
        #1;
        check("drop_idle_imem_addr", 32'(imem_addr), 32'd63);
        check("drop_idle_pc", 32'(pc), 32'd0);
        check("drop_idle_alu_op", 32'(alu_op), 32'd0);

        imem[0] = {NOP, 6'h01};
        imem[1] = {NOP, 6'h3F};
        run = 1'b1;
        @(posedge CLK); #1;
        next_instr(1'b0);
        check("nop_pc", 32'(pc), 32'd1);
        @(posedge CLK); #1;
        check("halt_decode_low", 32'(halted), 32'd0);
        @(posedge CLK); #1;
        check("halt_rise", 32'(halted), 32'd1);
        repeat (5) @(posedge CLK);
        #1;
        check("halt_imem_addr", 32'(imem_addr), 32'd1);
        check("halt_pc", 32'(pc), 32'd1);
        check("halt_hold", 32'(halted), 32'd1);

        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        check("rst_clears_halt", 32'(halted), 32'd0);
        imem[0] = enc(NOT, 2'd1, 2'd0, 2'd0);
        imem[1] = enc(ADD, 2'd2, 2'd1, 2'd1);
        @(posedge CLK); #1;
        next_instr(1'b0);
        check_reg("pre_rst_r1", 2'd1, 8'hFF);
        repeat (2) @(posedge CLK);
        #1;
        check("mid_exec_op", 32'({alu_op, alu_a, alu_b}), 32'({ADD, 8'hFF, 8'hFF}));
        RST = 1'b1; run = 1'b0;
        @(posedge CLK); #1;
        RST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reg("abort_r2", 2'd2, 8'h00);
        check_reg("abort_r1", 2'd1, 8'h00);
        check("abort_pc", 32'(pc), 32'd0);
        check("abort_carry", 32'(carry), 32'd0);
        check("abort_alu_op", 32'(alu_op), 32'd0);
        check("abort_imem_addr", 32'(imem_addr), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
